// File: rtl/apb_master_bridge.sv
// APB3 requester: turns one valid/ready command into a single SETUP+ACCESS transfer
// and returns read data, slave error and timeout status on a valid/ready response port.
module apb_master_bridge #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              prst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    // A zero TIMEOUT still needs a 1-bit counter so the declarations stay legal.
    localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pwrite_q, pwrite_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic                busy_q, busy_d;

    // NOTE: every *_d gets its hold value first, so no path through the case leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d   = cmd_addr;
                    pwrite_d  = cmd_write;
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A completing pready wins over a timeout landing on the same edge.
                if (pready) begin
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (TO_EN && cnt_q == CNT_LAST) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the values computed before this edge.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = busy_q;
    assign paddr       = paddr_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: table of single transfers against a
// responding APB slave model, plus hand sequences for back-pressure and mid-transfer reset.
module tb_apb_master_bridge;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              pclk = 1'b0;
    logic              prst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              busy;
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata = '0;
    logic              pready = 1'b0;
    logic              pslverr = 1'b0;

    apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .prst_n(prst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                waits;      // ACCESS cycles with pready low before it rises
        logic [DATA_W-1:0] prdata;
        logic              slverr;
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_err;
        logic              exp_to;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              to;
    } rsp_t;

    rsp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check_rsp(input string name);
        rsp_t e;
        check({name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s.scoreboard: got response, expected none queued", name);
        end else begin
            e = sb.pop_front();
            check({name, ".rdata"},   rsp_rdata,          e.rdata);
            check({name, ".err"},     32'(rsp_err),       32'(e.err));
            check({name, ".timeout"}, 32'(rsp_timeout),   32'(e.to));
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    pen_cnt;
        int    exp_pen;
        string tag;
        tag = $sformatf("vec%0d", idx);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        pready    = 1'b0;
        rsp_ready = 1'b1;
        check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err, to: v.exp_to});
        check({tag, ".setup_psel"},    32'(psel),    32'd1);
        check({tag, ".setup_penable"}, 32'(penable), 32'd0);
        check({tag, ".busy"},          32'(busy),    32'd1);
        check({tag, ".pwrite"},        32'(pwrite),  32'(v.write));
        check({tag, ".pwdata"},        pwdata,       v.write ? v.wdata : 32'd0);
        tick();
        pen_cnt = 0;
        while (psel && penable && pen_cnt < 100) begin
            check({tag, ".paddr_stable"}, 32'(paddr), 32'(v.addr));
            pready  = (pen_cnt == v.waits);
            prdata  = pready ? v.prdata : $urandom;
            pslverr = pready ? v.slverr : 1'b1;  // error on non-ready cycles must be ignored
            pen_cnt++;
            tick();
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        exp_pen = (v.waits >= TIMEOUT) ? TIMEOUT : v.waits + 1;
        check({tag, ".penable_cycles"}, 32'(pen_cnt), 32'(exp_pen));
        check({tag, ".resp_psel"}, 32'(psel), 32'd0);
        check_rsp(tag);
        tick();
        check({tag, ".rsp_consumed"}, 32'(rsp_valid), 32'd0);
        check({tag, ".idle_ready"},   32'(cmd_ready), 32'd1);
        check({tag, ".idle_busy"},    32'(busy),      32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 12'h004, 32'hDEADBEEF, 0,    32'h55AA55AA, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[1] = '{1'b0, 12'h008, 32'h0,        3,    32'h000000A5, 1'b0, 32'h000000A5, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 12'hFFC, 32'h0,        0,    32'h12345678, 1'b1, 32'h12345678, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 12'h100, 32'h0,        1000, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b1, 1'b1};
        vecs[4] = '{1'b1, 12'h3A0, 32'h0BADC0DE, 2,    32'h77777777, 1'b1, 32'h0,        1'b1, 1'b0};
        vecs[5] = '{1'b0, 12'h7F0, 32'h0,        15,   32'h600DF00D, 1'b0, 32'h600DF00D, 1'b0, 1'b0};

        // Reset values while prst_n is held low
        #12;
        check("rst.psel",        32'(psel),        32'd0);
        check("rst.penable",     32'(penable),     32'd0);
        check("rst.pwrite",      32'(pwrite),      32'd0);
        check("rst.paddr",       32'(paddr),       32'd0);
        check("rst.pwdata",      pwdata,           32'd0);
        check("rst.rsp_valid",   32'(rsp_valid),   32'd0);
        check("rst.rsp_rdata",   rsp_rdata,        32'd0);
        check("rst.rsp_err",     32'(rsp_err),     32'd0);
        check("rst.rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("rst.busy",        32'(busy),        32'd0);
        @(negedge pclk);
        prst_n = 1'b1;
        tick();
        check("rst.cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Back-to-back commands with the first response held off for 5 cycles
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 12'h010;
        cmd_wdata = 32'h11111111;
        pready    = 1'b1;
        prdata    = 32'hCAFEF00D;
        rsp_ready = 1'b0;
        tick();
        sb.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
        cmd_write = 1'b0;
        cmd_addr  = 12'h020;
        check("b2b.setup_psel", 32'(psel), 32'd1);
        tick();
        check("b2b.access_penable", 32'(penable), 32'd1);
        tick();
        check_rsp("b2b.first");
        for (int c = 0; c < 5; c++) begin
            tick();
            check("b2b.hold_valid",     32'(rsp_valid), 32'd1);
            check("b2b.hold_err",       32'(rsp_err),   32'd0);
            check("b2b.hold_rdata",     rsp_rdata,      32'd0);
            check("b2b.hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("b2b.hold_psel",      32'(psel),      32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        check("b2b.consumed",  32'(rsp_valid), 32'd0);
        check("b2b.cmd_ready", 32'(cmd_ready), 32'd1);
        check("b2b.idle_psel", 32'(psel),      32'd0);
        tick();
        sb.push_back('{rdata: 32'hCAFEF00D, err: 1'b0, to: 1'b0});
        cmd_valid = 1'b0;
        check("b2b.second_psel",  32'(psel),  32'd1);
        check("b2b.second_paddr", 32'(paddr), 32'h020);
        check("b2b.second_read",  32'(pwrite), 32'd0);
        tick();
        tick();
        check_rsp("b2b.second");
        tick();
        pready = 1'b0;
        check("b2b.done", 32'(busy), 32'd0);

        // Reset asserted in the middle of ACCESS
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h040;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("rst_mid.psel_before",    32'(psel),    32'd1);
        check("rst_mid.penable_before", 32'(penable), 32'd1);
        #2;
        prst_n = 1'b0;
        #1;
        check("rst_mid.psel",      32'(psel),      32'd0);
        check("rst_mid.penable",   32'(penable),   32'd0);
        check("rst_mid.busy",      32'(busy),      32'd0);
        check("rst_mid.rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge pclk);
        prst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_mid.no_rsp", 32'(rsp_valid), 32'd0);
        end
        run_vec('{1'b1, 12'h0C8, 32'hA5A5F00F, 1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0}, 6);

        check("sb.drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
